// File: rtl/alu_pkg.sv
// Shared types for the ALU issue front end: opcodes, FSM states, the queued
// request record and the overflow-flag rule.
package alu_pkg;

    localparam logic [2:0] ALU_OP_NOP = 3'b111;
    localparam int         REQ_TAG_W  = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_MUL = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_NOT = 3'b110,
        OP_NOP = ALU_OP_NOP
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [15:0]          a;
        logic [15:0]          b;
        alu_op_e              op;
        logic [REQ_TAG_W-1:0] tag;
    } alu_req_t;

    // bit 0: carry out of ADD or non-zero upper half of MUL; bit 1: SUB borrow
    function automatic logic [1:0] calc_ovf(alu_op_e op, logic [15:0] a, logic [15:0] b,
                                            logic [15:0] result_hi);
        logic [1:0] ovf;
        ovf = '0;
        case (op)
            OP_ADD:  ovf[0] = result_hi[0];
            OP_MUL:  ovf[0] = |result_hi;
            OP_SUB:  ovf[1] = (a < b);
            default: ovf = '0;
        endcase
        return ovf;
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO: wrap-around pointers plus an occupancy counter.
// A pop never frees a slot for a push in the same cycle (push is gated by full).
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push_i,
    input  alu_req_t data_i,
    output logic     full_o,
    input  logic     pop_i,
    output alu_req_t data_o,
    output logic     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    alu_req_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Valid/ready front end that queues ALU requests, holds them on the ALU for SETTLE
// cycles, and returns the captured result. Optional build macro: ALU_ISSUE_OPCODE_CHECK_EN.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1,
    parameter int TAG_W  = REQ_TAG_W  // must equal the tag width of alu_req_t
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [15:0]      req_a,
    input  logic [15:0]      req_b,
    input  logic [2:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    output logic [2:0]       alu_op,
    input  logic [31:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [1:0]       rsp_ovf,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
);
    localparam int               CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      alu_a_q, alu_a_d;
    logic [15:0]      alu_b_q, alu_b_d;
    alu_op_e          alu_op_q, alu_op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic [1:0]       rsp_ovf_q, rsp_ovf_d;
    logic             rsp_err_q, rsp_err_d;

    alu_req_t push_req, head_req;
    logic     fifo_full, fifo_empty, fifo_pop;
    logic     nop_reject;

    assign push_req.a   = req_a;
    assign push_req.b   = req_b;
    assign push_req.op  = alu_op_e'(req_op);
    assign push_req.tag = req_tag;

    alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (req_valid),
        .data_i  (push_req),
        .full_o  (fifo_full),
        .pop_i   (fifo_pop),
        .data_o  (head_req),
        .empty_o (fifo_empty)
    );

`ifdef ALU_ISSUE_OPCODE_CHECK_EN
    assign nop_reject = (head_req.op == OP_NOP);
`else
    assign nop_reject = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        tag_d        = tag_q;
        rsp_result_d = rsp_result_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_err_d    = rsp_err_q;
        fifo_pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    tag_d    = head_req.tag;
                    if (nop_reject) begin
                        // rejected opcode: answer immediately, ALU lines stay idle
                        rsp_result_d = '0;
                        rsp_ovf_d    = '0;
                        rsp_err_d    = 1'b1;
                        state_d      = ST_RESP;
                    end else begin
                        alu_a_d  = head_req.a;
                        alu_b_d  = head_req.b;
                        alu_op_d = head_req.op;
                        cnt_d    = CNT_LOAD;
                        state_d  = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt_q == '0) begin
                    rsp_result_d = alu_result;
                    rsp_ovf_d    = calc_ovf(alu_op_q, alu_a_q, alu_b_q, alu_result[31:16]);
                    rsp_err_d    = 1'b0;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    alu_a_d  = '0;
                    alu_b_d  = '0;
                    alu_op_d = OP_NOP;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= OP_NOP;
            tag_q        <= '0;
            rsp_result_q <= '0;
            rsp_ovf_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            tag_q        <= tag_d;
            rsp_result_q <= rsp_result_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready  = !fifo_full;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_result = rsp_result_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign rsp_tag    = tag_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed cases, back-pressure, reset in DRIVE,
// then randomized traffic against a behavioural ALU/flag model.
module tb_alu_issue_ctrl;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 3;
    localparam int TAG_W  = 4;
    localparam logic [34:0] IDLE_ALU = {16'h0000, 16'h0000, 3'b111};

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready;
    logic [15:0]      req_a, req_b;
    logic [2:0]       req_op;
    logic [TAG_W-1:0] req_tag;
    logic [15:0]      alu_a, alu_b;
    logic [2:0]       alu_op;
    logic [31:0]      alu_result;
    logic             rsp_valid, rsp_ready;
    logic [31:0]      rsp_result;
    logic [1:0]       rsp_ovf;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic             busy;

    typedef struct {
        logic [31:0] result;
        logic [1:0]  ovf;
        logic [3:0]  tag;
        logic        err;
        logic [34:0] alu;
        int          exp_rise;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   hs_count = 0;
    bit   rand_ready_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_ctrl #(.DEPTH(DEPTH), .SETTLE(SETTLE), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .rsp_tag(rsp_tag),
        .rsp_err(rsp_err), .busy(busy)
    );

    // Combinational ALU seen by the DUT; NOP yields zero.
    function automatic logic [31:0] alu_fn(logic [15:0] a, logic [15:0] b, logic [2:0] op);
        case (op)
            3'd0:    return 32'(a) + 32'(b);
            3'd1:    return 32'(a) * 32'(b);
            3'd2:    return 32'(a) - 32'(b);
            3'd3:    return {16'h0000, a & b};
            3'd4:    return {16'h0000, a | b};
            3'd5:    return {16'h0000, a ^ b};
            3'd6:    return {16'h0000, ~a};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [1:0] model_ovf(logic [15:0] a, logic [15:0] b, logic [2:0] op);
        int     sum;
        longint prod;
        sum  = int'(a) + int'(b);
        prod = longint'(a) * longint'(b);
        case (op)
            3'd0:    return {1'b0, sum > 65535};
            3'd1:    return {1'b0, prod > 65535};
            3'd2:    return {a < b, 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic bit chk_en();
`ifdef ALU_ISSUE_OPCODE_CHECK_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    always_comb alu_result = alu_fn(alu_a, alu_b, alu_op);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                        input logic [3:0] tag, input bit timed);
        exp_t e;
        int   n;
        bit   ok;
        req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
        n = 0; ok = 1'b0;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
            else n++;
        end
        check("req_accept", ok, 1'b1);
        if (ok) begin
            e.err      = chk_en() && (op == 3'b111);
            e.result   = e.err ? 32'h0 : alu_fn(a, b, op);
            e.ovf      = e.err ? 2'b00 : model_ovf(a, b, op);
            e.tag      = tag;
            e.alu      = e.err ? IDLE_ALU : {a, b, op};
            e.exp_rise = timed ? (cyc + (e.err ? 2 : 2 + SETTLE)) : -1;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    // Monitor: latency and operand stability at response rise, payload at handshake.
    logic        prev_valid = 1'b0;
    logic [34:0] prev_alu = IDLE_ALU;
    logic        glitch = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
            prev_alu   <= IDLE_ALU;
            glitch     <= 1'b0;
        end else begin
            if (!rsp_valid && !prev_valid && prev_alu != IDLE_ALU && {alu_a, alu_b, alu_op} != prev_alu)
                glitch <= 1'b1;
            if (rsp_valid && !prev_valid) begin
                check("rsp_pending", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    check("drive_operands", {alu_a, alu_b, alu_op}, sb[0].alu);
                    check("drive_stable", glitch, 1'b0);
                    if (sb[0].exp_rise >= 0) check("latency", cyc, sb[0].exp_rise);
                end
                glitch <= 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                hs_count <= hs_count + 1;
                check("hs_pending", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_result", rsp_result, e.result);
                    check("rsp_ovf", rsp_ovf, e.ovf);
                    check("rsp_tag", rsp_tag, e.tag);
                    check("rsp_err", rsp_err, e.err);
                end
            end
            prev_valid <= rsp_valid;
            prev_alu   <= {alu_a, alu_b, alu_op};
        end
    end

    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1;
            rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 3))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int hs_before;
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_alu_a", alu_a, 16'h0);
        check("rst_alu_b", alu_b, 16'h0);
        check("rst_alu_op", alu_op, 3'b111);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_result", rsp_result, 32'h0);
        check("rst_rsp_ovf", rsp_ovf, 2'b00);
        check("rst_rsp_tag", rsp_tag, 4'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed cases, each from an idle, empty front end
        send(16'hFFFF, 16'h0001, 3'd0, 4'h1, 1'b1); drain();
        send(16'd5,    16'd7,    3'd2, 4'h2, 1'b1); drain();
        send(16'h0100, 16'h0100, 3'd1, 4'h3, 1'b1); drain();
        send(16'h1234, 16'h5678, 3'd7, 4'hA, 1'b1); drain();

        // Back-pressure: one in flight, DEPTH queued
        rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++)
            send(16'($urandom), 16'($urandom), 3'(i), 4'(i + 4), 1'b0);
        @(negedge clk);
        check("full_req_ready", req_ready, 1'b0);
        check("full_busy", busy, 1'b1);
        repeat (SETTLE + 2) @(negedge clk);
        check("held_rsp_valid", rsp_valid, 1'b1);
        check("held_req_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drain();

        // Reset while the first request is in DRIVE with three behind it
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(16'($urandom), 16'($urandom), 3'd0, 4'(i + 8), 1'b0);
        check("pre_rst_in_drive", {rsp_valid, busy, alu_op != 3'b111}, 3'b011);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_alu_op", alu_op, 3'b111);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_req_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        hs_before = hs_count;
        repeat (30) @(negedge clk);
        check("post_rst_no_rsp", hs_count - hs_before, 0);
        @(posedge clk); #1;

        // Randomized traffic with random response back-pressure
        rand_ready_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            send(pick_operand(), pick_operand(), 3'($urandom_range(0, 7)), 4'(i), 1'b0);
        end
        rand_ready_en = 1'b0;
        @(posedge clk); #2;
        rsp_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog timeout");
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential front end for the combinational ALU. Accepts operation requests over a valid/ready handshake and queues them in a small FIFO. Drives each request onto the ALU operand/opcode lines, holding them stable for a fixed settle window, then captures the ALU result. Returns the result with overflow flags and a request tag over a valid/ready response channel.

## Interface
- DEPTH, 4, request FIFO entries; power of two, ≥2
- SETTLE, 1, cycles the ALU inputs are held before the result is captured; ≥1
- TAG_W, 4, request tag width

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept
- req_a  in  16  operand A
- req_b  in  16  operand B
- req_op  in  3  opcode (000 ADD, 001 MUL, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 NOT, 111 NOP)
- req_tag  in  TAG_W  caller tag, returned unchanged
- alu_a  out  16  ALU inputA
- alu_b  out  16  ALU inputB
- alu_op  out  3  ALU opcode
- alu_result  in  32  ALU result
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts
- rsp_result  out  32  captured result
- rsp_ovf  out  2  overflow flags
- rsp_tag  out  TAG_W  tag of the request
- rsp_err  out  1  request rejected
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Request accepted on any edge with req_valid && req_ready. req_ready = !full. A pop in the same cycle does not free a slot for a push.
- FSM states: IDLE, DRIVE, RESP.
- IDLE: alu_op = 3'b111, alu_a = alu_b = 0. If the FIFO is non-empty, pop the head, load alu_a/alu_b/alu_op and the tag, load the counter with SETTLE-1, then go to DRIVE.
- DRIVE: alu_* are held constant. Each cycle the counter decrements. When the counter is 0, capture alu_result into rsp_result, compute rsp_ovf, then go to RESP.
- RESP: rsp_valid = 1, and all rsp_* are held. On rsp_ready, clear rsp_valid and go to IDLE; alu_op returns to 111 on the same edge.
- rsp_ovf[0]: ADD → alu_result[16]; MUL → |alu_result[31:16]; otherwise 0.
- rsp_ovf[1]: SUB → (a < b) unsigned borrow; otherwise 0.
- rsp_result is always the full 32-bit ALU value, unmodified.
- Back-pressure: while in RESP the FIFO keeps accepting until full. No operation is issued until the response is taken.

## Timing
- Reset values: req_ready=1, alu_a=0, alu_b=0, alu_op=3'b111, rsp_valid=0, rsp_result=0, rsp_ovf=0, rsp_tag=0, rsp_err=0, busy=0. State is IDLE and the FIFO is empty.
- With the FSM in IDLE and the FIFO empty: a request accepted at edge N drives alu_* from edge N+1. The result is captured and rsp_valid rises at edge N+1+SETTLE.
- Back-to-back throughput is 1 operation per SETTLE+2 cycles when rsp_ready is held high.
- Reset asserted mid-operation: FIFO flushed, FSM to IDLE, all outputs to reset values on that edge. A pending response is dropped.

## Configuration
- ALU_ISSUE_OPCODE_CHECK_EN defined: a popped request with opcode 111 skips DRIVE. It goes directly to RESP with rsp_result=0, rsp_ovf=0, rsp_err=1, and alu_op stays 111.
- Undefined: opcode 111 is issued like any other opcode, the ALU result is returned, and rsp_err is tied 0.

## Structure
- Package alu_pkg holds:
  - opcode enum and constant ALU_OP_NOP = 3'b111
  - FSM state enum
  - request struct {a, b, op, tag}
- Sub-module alu_req_fifo: synchronous FIFO of request structs with push/pop/full/empty, DEPTH parameter, wrap-around pointers plus an occupancy counter.

## Test plan
- ADD a=16'hFFFF, b=16'h0001, SETTLE=1 → rsp_valid at edge N+2, rsp_result=32'h0001_0000, rsp_ovf=2'b01.
- SUB a=5, b=7 → rsp_result=32'hFFFF_FFFE, rsp_ovf=2'b10. MUL a=16'h0100, b=16'h0100 → 32'h0001_0000, rsp_ovf=2'b01.
- rsp_ready held low, 5 requests offered with DEPTH=4 → 1 in flight, 4 queued, req_ready=0. Release rsp_ready → tags returned in order and alu_* stable throughout each DRIVE.
- rst pulsed while in DRIVE with 3 queued → next edge: rsp_valid=0, alu_op=111, busy=0, no response emitted afterwards.
- Opcode 111, tag 4'hA → with ALU_ISSUE_OPCODE_CHECK_EN: rsp_err=1, rsp_result=0, tag 4'hA. Without the macro: rsp_err=0, rsp_result=0.
